// File: rtl/shift_pattern_sequencer.sv
// Sequencer for an 8-stage shift-register pattern generator (Johnson, ring, LFSR, counter)
// with start/pause/abort control, a programmable step prescaler and a frame-wrap marker.
module shift_pattern_sequencer #(
    parameter logic [7:0] LFSR_TAPS = 8'hB8,
    parameter logic [7:0] LFSR_SEED = 8'h01
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        RUN   = 2'd2,
        PAUSE = 2'd3
    } fsm_e;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode_in;
    logic [1:0] rate;

    assign clk     = io_in[0];
    assign rst     = io_in[1];
    assign start   = io_in[2];
    assign stop    = io_in[3];
    assign mode_in = io_in[5:4];
    assign rate    = io_in[7:6];

    fsm_e       fsm_q;
    logic [7:0] state_q;
    logic [1:0] mode_q;
    logic [2:0] presc_q;
    logic       wrap_q;

    logic [7:0] step_d;
    logic [2:0] limit;
    logic       tick;

    function automatic logic [7:0] seed_for(input logic [1:0] m);
        case (m)
            2'b01:   seed_for = 8'h01;
            2'b10:   seed_for = LFSR_SEED;
            default: seed_for = 8'h00;
        endcase
    endfunction

    always_comb begin
        step_d = state_q;
        case (mode_q)
            2'b00: step_d = {state_q[6:0], ~state_q[7]};
            2'b01: step_d = {state_q[6:0], state_q[7]};
            2'b10: step_d = {state_q[6:0], ^(state_q & LFSR_TAPS)};
            2'b11: step_d = state_q + 8'd1;
            default: step_d = state_q;
        endcase
    end

    // rate is sampled live; >= lets a lowered rate tick immediately
    always_comb begin
        limit = 3'((4'd1 << rate) - 4'd1);
        tick  = (fsm_q == RUN) && !stop && (presc_q >= limit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            mode_q  <= '0;
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start) fsm_q <= SEED;
                end
                SEED: begin
                    mode_q  <= mode_in;
                    state_q <= seed_for(mode_in);
                    presc_q <= '0;
                    fsm_q   <= RUN;
                end
                RUN: begin
                    if (stop) begin
                        fsm_q <= PAUSE;
                    end else if (tick) begin
                        state_q <= step_d;
                        presc_q <= '0;
                        wrap_q  <= (step_d == seed_for(mode_q));
                    end else begin
                        presc_q <= presc_q + 3'd1;
                    end
                end
                PAUSE: begin
                    if (start && stop)  fsm_q <= IDLE;
                    else if (start)     fsm_q <= RUN;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign io_out = {wrap_q, state_q[6:0]};

endmodule

// File: tb/tb_shift_pattern_sequencer.sv
// Directed self-checking bench for shift_pattern_sequencer: reset, each feedback mode,
// prescaler pacing, pause/resume/abort, mode latching and mid-run reset.
module tb_shift_pattern_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [1:0] rate;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [6:0] JTAB [16] = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h7F,
                                         7'h7E, 7'h7C, 7'h78, 7'h70, 7'h60, 7'h40, 7'h00, 7'h00};
    localparam logic [6:0] RTAB [8]  = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h00, 7'h01};
    localparam logic [6:0] LTAB [4]  = '{7'h02, 7'h04, 7'h08, 7'h11};

    assign io_in = {rate, mode, stop, start, rst, clk};

    shift_pattern_sequencer #(
        .LFSR_TAPS(8'hB8),
        .LFSR_SEED(8'h01)
    ) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        clk_step();
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        clk_step();
        start = 1'b0;
        clk_step();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; rate = 2'b00;
        clk_step();
        vectors++;
        if (io_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out: got %02h expected 00", io_out);
        end
        start = 1'b1;
        clk_step();
        vectors++;
        if (io_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_beats_start: got %02h expected 00", io_out);
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk_step();
            vectors++;
            if (io_out !== 8'h00) begin
                miscompares++;
                $display("FAIL idle_hold[%0d]: got %02h expected 00", i, io_out);
            end
        end
    endtask

    task automatic test_johnson();
        logic [7:0] exp;
        do_reset();
        mode = 2'b00; rate = 2'b00;
        start_pulse();
        vectors++;
        if (io_out !== 8'h00) begin
            miscompares++;
            $display("FAIL johnson_seed: got %02h expected 00", io_out);
        end
        for (int i = 0; i < 16; i++) begin
            clk_step();
            exp = {(i == 15), JTAB[i]};
            vectors++;
            if (io_out !== exp) begin
                miscompares++;
                $display("FAIL johnson_step[%0d]: got %02h expected %02h", i + 1, io_out, exp);
            end
        end
        clk_step();
        vectors++;
        if (io_out !== 8'h01) begin
            miscompares++;
            $display("FAIL johnson_after_wrap: got %02h expected 01", io_out);
        end
    endtask

    task automatic test_lfsr();
        logic [7:0] s;
        logic [7:0] exp;
        int first_wrap;
        do_reset();
        mode = 2'b10; rate = 2'b00;
        start_pulse();
        vectors++;
        if (io_out !== 8'h01) begin
            miscompares++;
            $display("FAIL lfsr_seed: got %02h expected 01", io_out);
        end
        s = 8'h01;
        first_wrap = 0;
        for (int i = 1; i <= 255; i++) begin
            s = {s[6:0], ^(s & 8'hB8)};
            clk_step();
            exp = {(s == 8'h01), s[6:0]};
            vectors++;
            if (io_out !== exp) begin
                miscompares++;
                $display("FAIL lfsr_step[%0d]: got %02h expected %02h", i, io_out, exp);
            end
            if (i <= 4) begin
                vectors++;
                if (io_out[6:0] !== LTAB[i-1]) begin
                    miscompares++;
                    $display("FAIL lfsr_table[%0d]: got %02h expected %02h", i, io_out[6:0], LTAB[i-1]);
                end
            end
            if (io_out[7] === 1'b1 && first_wrap == 0) first_wrap = i;
        end
        vectors++;
        if (first_wrap != 255) begin
            miscompares++;
            $display("FAIL lfsr_period: got %0d expected 255", first_wrap);
        end
    endtask

    task automatic test_ring_rate2();
        logic [6:0] cur;
        logic [7:0] exp;
        do_reset();
        mode = 2'b01; rate = 2'b10;
        start = 1'b1;
        clk_step();
        clk_step();
        cur = 7'h01;
        vectors++;
        if (io_out !== 8'h01) begin
            miscompares++;
            $display("FAIL ring_seed: got %02h expected 01", io_out);
        end
        for (int j = 0; j < 8; j++) begin
            for (int c = 0; c < 3; c++) begin
                clk_step();
                vectors++;
                if (io_out !== {1'b0, cur}) begin
                    miscompares++;
                    $display("FAIL ring_hold[%0d.%0d]: got %02h expected %02h", j, c, io_out, {1'b0, cur});
                end
            end
            clk_step();
            cur = RTAB[j];
            exp = {(j == 7), cur};
            vectors++;
            if (io_out !== exp) begin
                miscompares++;
                $display("FAIL ring_step[%0d]: got %02h expected %02h", j + 1, io_out, exp);
            end
        end
        clk_step();
        vectors++;
        if (io_out !== 8'h01) begin
            miscompares++;
            $display("FAIL ring_wrap_onecycle: got %02h expected 01", io_out);
        end
        start = 1'b0;
    endtask

    task automatic test_pause();
        logic [7:0] exp;
        do_reset();
        mode = 2'b11; rate = 2'b00;
        start_pulse();
        for (int i = 1; i <= 3; i++) begin
            clk_step();
            exp = 8'(i);
            vectors++;
            if (io_out !== exp) begin
                miscompares++;
                $display("FAIL pause_run[%0d]: got %02h expected %02h", i, io_out, exp);
            end
        end
        stop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            vectors++;
            if (io_out !== 8'h03) begin
                miscompares++;
                $display("FAIL pause_frozen[%0d]: got %02h expected 03", i, io_out);
            end
        end
        stop = 1'b0; start = 1'b1;
        clk_step();
        vectors++;
        if (io_out !== 8'h03) begin
            miscompares++;
            $display("FAIL pause_resume_edge: got %02h expected 03", io_out);
        end
        start = 1'b0;
        clk_step();
        vectors++;
        if (io_out !== 8'h04) begin
            miscompares++;
            $display("FAIL pause_resume_step: got %02h expected 04", io_out);
        end
        stop = 1'b1;
        clk_step();
        start = 1'b1;
        clk_step();
        vectors++;
        if (io_out !== 8'h04) begin
            miscompares++;
            $display("FAIL abort_retain: got %02h expected 04", io_out);
        end
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clk_step();
            vectors++;
            if (io_out !== 8'h04) begin
                miscompares++;
                $display("FAIL abort_idle[%0d]: got %02h expected 04", i, io_out);
            end
        end
        mode = 2'b01;
        start_pulse();
        vectors++;
        if (io_out !== 8'h01) begin
            miscompares++;
            $display("FAIL abort_reseed: got %02h expected 01", io_out);
        end
    endtask

    task automatic test_rate_change();
        do_reset();
        mode = 2'b11; rate = 2'b11;
        start_pulse();
        for (int i = 0; i < 3; i++) begin
            clk_step();
            vectors++;
            if (io_out !== 8'h00) begin
                miscompares++;
                $display("FAIL rate3_hold[%0d]: got %02h expected 00", i, io_out);
            end
        end
        rate = 2'b01;
        clk_step();
        vectors++;
        if (io_out !== 8'h01) begin
            miscompares++;
            $display("FAIL rate_lower_tick: got %02h expected 01", io_out);
        end
        clk_step();
        vectors++;
        if (io_out !== 8'h01) begin
            miscompares++;
            $display("FAIL rate1_hold: got %02h expected 01", io_out);
        end
        clk_step();
        vectors++;
        if (io_out !== 8'h02) begin
            miscompares++;
            $display("FAIL rate1_step: got %02h expected 02", io_out);
        end
    endtask

    task automatic test_mode_latch();
        logic [7:0] exp;
        do_reset();
        mode = 2'b11; rate = 2'b00;
        start_pulse();
        vectors++;
        if (io_out !== 8'h00) begin
            miscompares++;
            $display("FAIL counter_seed: got %02h expected 00", io_out);
        end
        for (int i = 1; i <= 256; i++) begin
            if (i == 6) mode = 2'b00;
            clk_step();
            exp = {(i == 256), 7'(i)};
            vectors++;
            if (io_out !== exp) begin
                miscompares++;
                $display("FAIL counter_step[%0d]: got %02h expected %02h", i, io_out, exp);
            end
        end
        stop = 1'b1;
        clk_step();
        start = 1'b1;
        clk_step();
        stop = 1'b0;
        start_pulse();
        clk_step();
        vectors++;
        if (io_out !== 8'h01) begin
            miscompares++;
            $display("FAIL newmode_step1: got %02h expected 01", io_out);
        end
        clk_step();
        vectors++;
        if (io_out !== 8'h03) begin
            miscompares++;
            $display("FAIL newmode_step2: got %02h expected 03", io_out);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        mode = 2'b11; rate = 2'b00;
        start_pulse();
        repeat (42) clk_step();
        vectors++;
        if (io_out !== 8'h2A) begin
            miscompares++;
            $display("FAIL midrun_value: got %02h expected 2a", io_out);
        end
        rst = 1'b1;
        clk_step();
        vectors++;
        if (io_out !== 8'h00) begin
            miscompares++;
            $display("FAIL midrun_reset: got %02h expected 00", io_out);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mode = 2'(k);
            rate = 2'(3 - k);
            clk_step();
            vectors++;
            if (io_out !== 8'h00) begin
                miscompares++;
                $display("FAIL post_reset_idle[%0d]: got %02h expected 00", k, io_out);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; rate = 2'b00;
        test_reset();
        test_johnson();
        test_lfsr();
        test_ring_rate2();
        test_pause();
        test_rate_change();
        test_mode_latch();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_pattern_sequencer.md
Name: shift_pattern_sequencer

Overview:
- Controller and sequencer for an 8-stage shift-register pattern generator on the standard 8-in/8-out user-module pin bundle.
- Sequences start, run, pause and abort of the pattern generator.
- Selects the feedback type (Johnson, ring, LFSR, binary count) and paces stepping with a programmable prescaler.
- Drives the low 7 state bits plus a one-cycle frame-wrap marker.

Parameters:
- LFSR_TAPS, 8'hB8, feedback tap mask for LFSR mode (XOR of state bits where mask=1; default is x^8+x^6+x^5+x^4+1).
- LFSR_SEED, 8'h01, nonzero seed loaded in LFSR mode.

Ports:
- io_in[0]  input  1  clock (all logic on rising edge).
- io_in[1]  input  1  reset; synchronous, active-high.
- io_in[2]  input  1  start (level).
- io_in[3]  input  1  stop (level).
- io_in[5:4]  input  2  mode: 00 Johnson, 01 ring, 10 LFSR, 11 binary counter.
- io_in[7:6]  input  2  rate: step every 2^rate clocks while running (1/2/4/8).
- io_out[6:0]  output  7  pattern = state[6:0].
- io_out[7]  output  1  wrap marker.

Behaviour:
- Internal registers: 8-bit state, 2-bit latched mode, 3-bit prescaler count, FSM, registered wrap flag.
- Reset (io_in[1]=1 at a clock edge) overrides everything:
  - FSM=IDLE, state=0x00, prescaler=0, wrap=0, latched mode=00.
  - io_out=0x00 from the next cycle.
  - Applies mid-run with no completion of the current step.
- FSM states IDLE, SEED, RUN, PAUSE:
  - IDLE: state holds. start=1 -> SEED.
  - SEED (1 cycle): latch io_in[5:4] as mode; load seed (Johnson 0x00, ring 0x01, LFSR LFSR_SEED, counter 0x00); prescaler=0; -> RUN.
  - RUN:
    - stop=1 -> PAUSE, with no step that cycle (stop beats tick); prescaler holds.
    - Else, on tick, state advances one step.
  - PAUSE: state and prescaler hold.
    - start=1, stop=0 -> RUN.
    - start=1, stop=1 -> IDLE (abort; state retained, visible on outputs).
    - Otherwise stay.
- Mode changes on io_in[5:4] after SEED are ignored until the next IDLE->SEED pass.
- Prescaler and tick:
  - In RUN without stop: tick = (prescaler >= 2^rate - 1).
  - On tick, prescaler <= 0; else prescaler <= prescaler+1.
  - rate is sampled live; lowering rate mid-count gives an immediate tick via the >= compare.
  - Outside RUN the prescaler does not count.
- Step functions (s = current state):
  - Johnson: {s[6:0], ~s[7]}; period 16.
  - Ring: {s[6:0], s[7]}; period 8.
  - LFSR: {s[6:0], ^(s & LFSR_TAPS)}; period 255.
  - Counter: s+1 mod 256; period 256.
- Latency:
  - IDLE+start at edge k -> SEED; seed visible after edge k+1.
  - With rate=0 the first step is visible after edge k+2, then one step per edge.
- Wrap marker:
  - wrap <= 1 on an edge where a tick step produces next state == the latched mode's seed; else 0.
  - io_out[7] is high exactly in the cycle the seed value reappears.
  - Never set by the SEED load itself, by reset, or while paused.
- Start held high in RUN has no effect. Start and stop both high in RUN -> PAUSE.
- All outputs are registered; no combinational path from io_in to io_out.

Test Plan:
- Reset then mode=00, rate=0, start pulse:
  - io_out[6:0] sequence 0x00,0x01,0x03,0x07,0x0F,0x1F,0x3F,0x7F,0x7F,0x7E,0x7C,...,0x00.
  - io_out[7]=1 only on the 16th step.
- Mode=10, rate=0:
  - Steps 0x01,0x02,0x04,0x08,0x11.
  - First io_out[7] pulse exactly 255 ticks after seed; never all-zero state.
- Mode=01, rate=2:
  - State changes every 4 clocks.
  - io_out[6:0] 0x01,0x02,...,0x40,0x00 then 0x01 with io_out[7]=1.
- Stop asserted in RUN on a tick cycle:
  - No step that cycle; outputs frozen.
  - start=1, stop=0 resumes with the next state in sequence.
  - start=1, stop=1 in PAUSE -> IDLE; later start reseeds.
- Mode=11, change io_in[5:4] to 00 mid-run:
  - Counter continues 0x05,0x06,...
  - Wrap pulse after 256 ticks; new mode used only after abort and restart.
- Assert reset mid-run (counter at 0x2A):
  - Next cycle io_out=0x00; FSM IDLE; outputs stay 0 with start=0 and rate/mode toggling.
